// File: rtl/reg_ctl_pkg.sv
// Shared constants for the register-overlay frame-rate controller:
// the RUN/PAUSE state encoding and the default timing parameters.
package reg_ctl_pkg;

  // Two-state controller encoding, kept as plain constants so older tools
  // that see the state register see an ordinary bit.
  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_PAUSE = 1'b1;

  // Auto-increment every 2^4 frames (roughly a quarter second at 70 Hz).
  localparam int DEF_PRESCALE_BITS = 4;

  // Number of consecutive frame samples needed before a button level is believed.
  localparam int DEF_DEB_FRAMES = 3;

  // Value shown by the overlay straight after reset.
  localparam logic [15:0] DEF_INIT = 16'h0019;

endpackage

// File: rtl/btn_debounce.sv
// Frame-rate button debouncer: synchronises one asynchronous button,
// samples it once per frame tick and reports a single press event
// when a new high level has been seen on DEB_FRAMES consecutive ticks.
module btn_debounce
  import reg_ctl_pkg::*;
#(
  parameter int DEB_FRAMES = DEF_DEB_FRAMES
) (
  input  logic px_clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press
);

  // The counter flips the level when it has already counted DEB_FRAMES-1
  // disagreeing ticks and the current tick disagrees again.
  localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic [3:0] r_cnt;

  logic w_differs;
  logic w_accept;

  assign w_differs = (r_sync2 != r_level);
  assign w_accept  = tick & w_differs & (r_cnt == DEB_LAST);

  // The press is combinational with the accepting tick so the controller
  // acts on the same frame the level flips, not one frame later.
  assign press = w_accept & r_sync2;
  assign level = r_level;

  // Two-flop synchroniser bringing the raw button into the pixel clock domain.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Tick-sampled disagreement counter; any agreeing sample restarts it,
  // so bounces shorter than DEB_FRAMES frames never reach the level.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_level <= 1'b0;
    end else if (tick) begin
      if (!w_differs) begin
        r_cnt <= 4'd0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/reg_frame_ctl.sv
// Frame-rate controller for the on-screen register overlay. Counts frame
// ends, auto-increments the shown value while running, and lets the player
// pause and single-step it with debounced buttons. Single clock domain.
module reg_frame_ctl
  import reg_ctl_pkg::*;
#(
  parameter int           W             = 16,
  parameter int           PRESCALE_BITS = DEF_PRESCALE_BITS,
  parameter int           DEB_FRAMES    = DEF_DEB_FRAMES,
  parameter logic [W-1:0] INIT          = W'(DEF_INIT)
) (
  input  logic         px_clk,
  input  logic         rst,
  input  logic         endframe,
  input  logic         btn_run,
  input  logic         btn_up,
  input  logic         btn_down,
  output logic [W-1:0] register,
  output logic         running,
  output logic         frame_tick
);

  localparam logic [PRESCALE_BITS-1:0] PRESC_MAX = '1;
  localparam logic [PRESCALE_BITS-1:0] PRESC_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]             REG_ONE   = {{(W-1){1'b0}}, 1'b1};

  logic                     r_ef_sync1;
  logic                     r_ef_sync2;
  logic                     r_ef_prev;
  logic                     r_tick;
  logic [PRESCALE_BITS-1:0] r_presc;
  logic                     r_state;
  logic [W-1:0]             r_register;

  logic w_run_press;
  logic w_up_press;
  logic w_down_press;
  logic w_unused_level_run;
  logic w_unused_level_up;
  logic w_unused_level_down;

  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_run (
    .px_clk (px_clk),
    .rst    (rst),
    .tick   (r_tick),
    .btn    (btn_run),
    .level  (w_unused_level_run),
    .press  (w_run_press)
  );

  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_up (
    .px_clk (px_clk),
    .rst    (rst),
    .tick   (r_tick),
    .btn    (btn_up),
    .level  (w_unused_level_up),
    .press  (w_up_press)
  );

  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_deb_down (
    .px_clk (px_clk),
    .rst    (rst),
    .tick   (r_tick),
    .btn    (btn_down),
    .level  (w_unused_level_down),
    .press  (w_down_press)
  );

  // Synchronise endframe and turn its rising edge into one registered tick,
  // so a long endframe level still yields a single pulse per frame.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_ef_sync1 <= 1'b0;
      r_ef_sync2 <= 1'b0;
      r_ef_prev  <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      r_ef_sync1 <= endframe;
      r_ef_sync2 <= r_ef_sync1;
      r_ef_prev  <= r_ef_sync2;
      r_tick     <= r_ef_sync2 & ~r_ef_prev;
    end
  end

  // Per-frame controller: a run/pause toggle wins and restarts the prescaler;
  // otherwise RUN auto-increments on prescaler wrap and PAUSE applies steps.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_presc    <= '0;
      r_register <= INIT;
    end else if (r_tick) begin
      if (w_run_press) begin
        r_state <= (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
        r_presc <= '0;
      end else if (r_state == ST_RUN) begin
        r_presc <= r_presc + PRESC_ONE;
        if (r_presc == PRESC_MAX) begin
          r_register <= r_register + REG_ONE;
        end
      end else if (w_up_press && !w_down_press) begin
        r_register <= r_register + REG_ONE;
      end else if (w_down_press && !w_up_press) begin
        r_register <= r_register - REG_ONE;
      end
    end
  end

  assign register   = r_register;
  assign running    = (r_state == ST_RUN);
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_reg_frame_ctl.sv
// Directed bench for reg_frame_ctl. Two instances share all stimulus, one
// with the default INIT and one with INIT=16'hFFFF to exercise wrap-around.
// A frame-level reference model predicts each frame's result, pushes it to
// a scoreboard queue, and the entry is popped once the DUT has updated.
module tb_reg_frame_ctl;

  logic        pxClk    = 1'b0;
  logic        rst      = 1'b1;
  logic        endframe = 1'b0;
  logic        btnRun   = 1'b0;
  logic        btnUp    = 1'b0;
  logic        btnDown  = 1'b0;

  logic [15:0] register1;
  logic [15:0] register2;
  logic        running1;
  logic        running2;
  logic        frameTick1;
  logic        frameTick2;

  int testsRun    = 0;
  int testsFailed = 0;
  int tickCount   = 0;

  typedef struct {
    logic [15:0] reg1;
    logic [15:0] reg2;
    logic        run;
  } expT;

  expT expQ[$];

  logic [15:0] mReg;
  logic        mRun;
  int          mPresc;
  logic [2:0]  mLvl;
  int          mCnt[3];

  reg_frame_ctl #(.INIT(16'h0019)) dut (
    .px_clk     (pxClk),
    .rst        (rst),
    .endframe   (endframe),
    .btn_run    (btnRun),
    .btn_up     (btnUp),
    .btn_down   (btnDown),
    .register   (register1),
    .running    (running1),
    .frame_tick (frameTick1)
  );

  reg_frame_ctl #(.INIT(16'hFFFF)) dutWrap (
    .px_clk     (pxClk),
    .rst        (rst),
    .endframe   (endframe),
    .btn_run    (btnRun),
    .btn_up     (btnUp),
    .btn_down   (btnDown),
    .register   (register2),
    .running    (running2),
    .frame_tick (frameTick2)
  );

  // Free-running pixel clock.
  always #5 pxClk = ~pxClk;

  // Count frame ticks from the default instance so each frame can be
  // checked for exactly one pulse.
  always @(posedge pxClk) begin
    if (frameTick1) tickCount <= tickCount + 1;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mReg   = 16'h0019;
    mRun   = 1'b1;
    mPresc = 0;
    mLvl   = 3'b000;
    for (int i = 0; i < 3; i++) mCnt[i] = 0;
  endtask

  // Reference behaviour for one frame tick with the given sampled buttons
  // (index 0 = run, 1 = up, 2 = down).
  task automatic modelFrame(input logic run, input logic up, input logic down);
    logic [2:0] smp;
    logic [2:0] prs;
    smp = {down, up, run};
    prs = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (smp[i] !== mLvl[i]) begin
        if (mCnt[i] + 1 == 3) begin
          mLvl[i] = smp[i];
          mCnt[i] = 0;
          prs[i]  = smp[i];
        end else begin
          mCnt[i] = mCnt[i] + 1;
        end
      end else begin
        mCnt[i] = 0;
      end
    end
    if (prs[0]) begin
      mRun   = !mRun;
      mPresc = 0;
    end else if (mRun) begin
      if (mPresc == 15) mReg = mReg + 16'd1;
      mPresc = (mPresc + 1) % 16;
    end else if (prs[1] && !prs[2]) begin
      mReg = mReg + 16'd1;
    end else if (prs[2] && !prs[1]) begin
      mReg = mReg - 16'd1;
    end
  endtask

  task automatic checkOutput(input string tag);
    expT e;
    testsRun++;
    assert (expQ.size() > 0) else begin
      testsFailed++;
      $error("[TB] FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkValue({tag, "_register"}, 32'(register1), 32'(e.reg1));
      checkValue({tag, "_register_wrap"}, 32'(register2), 32'(e.reg2));
      checkValue({tag, "_running"}, 32'(running1), 32'(e.run));
      checkValue({tag, "_running_wrap"}, 32'(running2), 32'(e.run));
    end
  endtask

  // One frame: set button levels, let them synchronise, pulse endframe for
  // efLen cycles, then check tick latency, tick count, stability at the
  // tick and the updated outputs.
  task automatic applyStimulus(input logic run, input logic up, input logic down, input int efLen, input string tag);
    logic [15:0] prevReg;
    logic [15:0] regAtTick;
    int          lat;
    int          startTicks;
    btnRun  = run;
    btnUp   = up;
    btnDown = down;
    repeat (4) @(posedge pxClk);
    #1;
    prevReg = mReg;
    modelFrame(run, up, down);
    expQ.push_back('{mReg, mReg + 16'hFFE6, mRun});
    startTicks = tickCount;
    lat        = 0;
    regAtTick  = 16'h0;
    endframe   = 1'b1;
    for (int n = 1; n <= efLen + 8; n++) begin
      @(posedge pxClk);
      #1;
      if (n == efLen) endframe = 1'b0;
      if (frameTick1 && lat == 0) begin
        lat       = n;
        regAtTick = register1;
      end
    end
    checkValue({tag, "_tick_latency"}, 32'(lat), 32'd3);
    checkValue({tag, "_tick_count"}, 32'(tickCount - startTicks), 32'd1);
    checkValue({tag, "_stable_at_tick"}, 32'(regAtTick), 32'(prevReg));
    checkOutput(tag);
  endtask

  task automatic runFrames(input int count, input logic run, input logic up, input logic down, input string tag);
    for (int i = 0; i < count; i++) applyStimulus(run, up, down, 2, tag);
  endtask

  // Directed sequence covering auto-increment, wrap, pause, stepping,
  // glitch rejection, endframe length and reset mid-operation.
  initial begin
    resetModel();
    repeat (3) @(posedge pxClk);
    #1;
    checkValue("reset_register", 32'(register1), 32'h0019);
    checkValue("reset_register_wrap", 32'(register2), 32'hFFFF);
    checkValue("reset_running", 32'(running1), 32'd1);
    checkValue("reset_frame_tick", 32'(frameTick1), 32'd0);
    rst = 1'b0;

    runFrames(15, 1'b0, 1'b0, 1'b0, "auto_pre16");
    runFrames(1, 1'b0, 1'b0, 1'b0, "auto_tick16");
    checkValue("auto16_value", 32'(register1), 32'h001A);
    checkValue("wrap16_value", 32'(register2), 32'h0000);
    runFrames(16, 1'b0, 1'b0, 1'b0, "auto_to32");
    checkValue("auto32_value", 32'(register1), 32'h001B);

    runFrames(3, 1'b1, 1'b0, 1'b0, "pause_press");
    checkValue("pause_running", 32'(running1), 32'd0);
    runFrames(64, 1'b0, 1'b0, 1'b0, "pause_hold");

    runFrames(3, 1'b0, 1'b0, 1'b1, "step_down_a");
    runFrames(3, 1'b0, 1'b0, 1'b0, "step_release_a");
    checkValue("step_zero", 32'(register2), 32'h0000);
    runFrames(10, 1'b0, 1'b1, 1'b0, "step_up_long");
    runFrames(3, 1'b0, 1'b0, 1'b0, "step_release_b");
    checkValue("step_up_once", 32'(register2), 32'h0001);
    runFrames(3, 1'b0, 1'b0, 1'b1, "step_down_b");
    runFrames(3, 1'b0, 1'b0, 1'b0, "step_release_c");
    runFrames(3, 1'b0, 1'b0, 1'b1, "step_down_c");
    runFrames(3, 1'b0, 1'b0, 1'b0, "step_release_d");
    checkValue("step_wrap_down", 32'(register2), 32'hFFFF);
    runFrames(3, 1'b0, 1'b1, 1'b1, "step_both");
    runFrames(3, 1'b0, 1'b0, 1'b0, "step_release_e");

    runFrames(2, 1'b0, 1'b1, 1'b0, "glitch_up");
    runFrames(4, 1'b0, 1'b0, 1'b0, "glitch_release");
    applyStimulus(1'b0, 1'b0, 1'b0, 1, "ef_short");
    applyStimulus(1'b0, 1'b0, 1'b0, 5000, "ef_long");

    runFrames(3, 1'b1, 1'b0, 1'b0, "resume_press");
    checkValue("resume_running", 32'(running1), 32'd1);
    runFrames(20, 1'b0, 1'b0, 1'b0, "resume_auto");

    runFrames(3, 1'b1, 1'b0, 1'b0, "rst_pause");
    runFrames(3, 1'b0, 1'b0, 1'b0, "rst_release");
    runFrames(2, 1'b1, 1'b0, 1'b0, "rst_partial");
    @(posedge pxClk);
    #1;
    rst = 1'b1;
    @(posedge pxClk);
    #1;
    rst = 1'b0;
    resetModel();
    checkValue("midrst_register", 32'(register1), 32'h0019);
    checkValue("midrst_register_wrap", 32'(register2), 32'hFFFF);
    checkValue("midrst_running", 32'(running1), 32'd1);
    checkValue("midrst_frame_tick", 32'(frameTick1), 32'd0);
    runFrames(1, 1'b1, 1'b0, 1'b0, "midrst_one_more");
    checkValue("midrst_still_running", 32'(running1), 32'd1);
    runFrames(2, 1'b1, 1'b0, 1'b0, "midrst_fresh_press");
    checkValue("midrst_paused", 32'(running1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
